// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, full-matrix snapshot, press/release debounce.
// Optional auto-repeat of key_valid is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 99_999,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

    localparam logic [16:0] TICK_MAX = 17'(SCAN_TICKS);
    localparam logic [3:0]  DB       = 4'(DEBOUNCE_SCANS);

    state_t      state, state_nxt;
    logic [3:0]  row_meta, row_sync;
    logic [16:0] timer;
    logic [1:0]  col_index;
    logic [15:0] snapshot;
    logic        scan_done;
    logic [3:0]  cnt, cnt_nxt, cand, cand_nxt;
    logic [4:0]  ones;
    logic [3:0]  hit_idx;
    logic        none, single;
    logic        enter_press, rpt_fire, held_nxt;

    // Rows are sampled at the end of each slot so they have the whole slot to settle.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            timer     <= '0;
            col_index <= '0;
            snapshot  <= '0;
            scan_done <= 1'b0;
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            scan_done <= 1'b0;
            if (timer == TICK_MAX) begin
                timer                            <= '0;
                col_index                        <= col_index + 2'd1;
                snapshot[{col_index, 2'b00} +: 4] <= ~row_sync;
                scan_done                        <= (col_index == 2'd3);
            end else begin
                timer <= timer + 17'd1;
            end
        end
    end

    assign col = ~(4'b0001 << col_index);

    always_comb begin
        ones    = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                ones    = ones + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign none   = (ones == 5'd0);
    assign single = (ones == 5'd1);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cand_nxt    = cand;
        enter_press = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        cand_nxt = hit_idx;
                        cnt_nxt  = 4'd1;
                        if (DB == 4'd1) begin
                            state_nxt   = PRESSED;
                            enter_press = 1'b1;
                        end else begin
                            state_nxt = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (single && hit_idx == cand) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt + 4'd1 == DB) begin
                            state_nxt   = PRESSED;
                            enter_press = 1'b1;
                        end
                    end else if (single) begin
                        cand_nxt = hit_idx;
                        cnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                PRESSED: begin
                    if (none) begin
                        cnt_nxt   = 4'd1;
                        state_nxt = (DB == 4'd1) ? IDLE : REL_DB;
                    end
                end
                REL_DB: begin
                    if (none) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt + 4'd1 == DB) state_nxt = IDLE;
                    end else begin
                        state_nxt = PRESSED;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign held_nxt = (state_nxt == PRESSED) || (state_nxt == REL_DB);

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rpt_cnt;
    logic        rpt_step, rpt_last;

    // Any scan with a key down while held (PRESSED stays, or REL_DB bounces back) counts.
    assign rpt_step = scan_done && !none && (state == PRESSED || state == REL_DB);
    assign rpt_last = (rpt_cnt == 16'(REPEAT_SCANS - 1));
    assign rpt_fire = rpt_step && rpt_last;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset)                        rpt_cnt <= '0;
        else if (enter_press || !held_nxt) rpt_cnt <= '0;
        else if (rpt_step)                rpt_cnt <= rpt_last ? 16'd0 : rpt_cnt + 16'd1;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            key_valid <= enter_press || rpt_fire;
            if (enter_press) key_code <= cand_nxt;
        end
    end

    assign key_held  = (state == PRESSED) || (state == REL_DB);
    assign fsm_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated keypad matrix, scan-level behavioural model, per-cycle compare.
module tb_keypad_scanner;

    localparam int DB  = 3;
    localparam int RPT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held;
    logic [1:0]  fsm_state;
    logic [15:0] mask = '0;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scanner #(.SCAN_TICKS(9), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RPT)) dut (
        .clk_100MHz(clk), .reset(reset), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && mask[4*c+r]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0t): got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Scan-level model: run lengths of identical single-key scans and of empty scans.
    bit         m_held, exp_pulse;
    int         m_code, m_run_key, m_run, m_rel, m_rpt;

    task automatic model_clear();
        m_held = 0; exp_pulse = 0; m_code = 0; m_run_key = 0; m_run = 0; m_rel = 0; m_rpt = 0;
    endtask

    task automatic model_scan(input logic [15:0] m);
        int n, k;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        exp_pulse = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_run > 0 && k == m_run_key) m_run++;
                else begin m_run_key = k; m_run = 1; end
                if (m_run == DB) begin
                    m_held = 1; m_code = k; exp_pulse = 1; m_rel = 0; m_rpt = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (n == 0) begin
            m_rel++;
            if (m_rel == DB) begin m_held = 0; m_run = 0; m_rpt = 0; end
        end else begin
            m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
            m_rpt++;
            if (m_rpt == RPT) begin exp_pulse = 1; m_rpt = 0; end
`endif
        end
    endtask

    bit          checking = 0;
    int          cyc = 0;
    int          first_pulse, pulse_cnt, held_fall;
    bit          prev_held;
    logic [15:0] scan_mask;

    always @(negedge clk) begin
        if (checking) begin
            int j;
            logic [3:0] exp_col;
            j = cyc % 40;
            if (j == 1 && cyc >= 40) model_scan(scan_mask);
            else if (j == 2) exp_pulse = 0;
            if (j == 39) scan_mask = mask;
            exp_col = ~(4'b0001 << ((cyc / 10) % 4));
            check("col", 32'(col), 32'(exp_col));
            check("key_valid", 32'(key_valid), 32'(exp_pulse));
            check("key_held", 32'(key_held), 32'(m_held));
            check("key_code", 32'(key_code), 32'(m_code));
            if (key_valid === 1'b1) begin
                pulse_cnt++;
                if (first_pulse < 0) first_pulse = cyc;
            end
            if (prev_held && key_held === 1'b0 && held_fall < 0) held_fall = cyc;
            prev_held = (key_held === 1'b1);
            cyc++;
        end
    end

    task automatic do_reset();
        checking = 0;
        reset    = 1'b1;
        mask     = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", 32'(col), 32'h E);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_code", 32'(key_code), 0);
        #1;
        reset = 1'b0;
        cyc = 0; first_pulse = -1; pulse_cnt = 0; held_fall = -1; prev_held = 0;
        checking = 1;
    endtask

    // Each scan starts just after a posedge, so the mask is stable for all four samples.
    task automatic run_scans(input logic [15:0] m, input int n);
        mask = m;
        repeat (40 * n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Idle: col rotation and quiet outputs are checked every cycle.
        do_reset();
        run_scans(16'h0000, 10);
        check("idle_pulses", 32'(pulse_cnt), 0);

        // Key at col 2 row 1 -> code 9.
        do_reset();
        run_scans(16'h0200, 6);
        run_scans(16'h0000, 4);
        check("k9_pulse_cyc", 32'(first_pulse), 121);
        check("k9_pulses", 32'(pulse_cnt), 1);
        check("k9_code", 32'(key_code), 9);
        check("k9_fall_cyc", 32'(held_fall), 361);

        // Bounce: 2 present, 1 absent, 3 present.
        do_reset();
        run_scans(16'h0200, 2);
        run_scans(16'h0000, 1);
        run_scans(16'h0200, 3);
        run_scans(16'h0000, 4);
        check("bounce_pulses", 32'(pulse_cnt), 1);
        check("bounce_pulse_cyc", 32'(first_pulse), 241);

        // Ghosting: keys 0 and 5, then key 5 released.
        do_reset();
        run_scans(16'h0021, 3);
        check("ghost_pulses", 32'(pulse_cnt), 0);
        run_scans(16'h0001, 4);
        check("ghost_pulse_cyc", 32'(first_pulse), 241);
        check("ghost_pulses2", 32'(pulse_cnt), 1);
        check("ghost_held", 32'(key_held), 1);

        // Reset mid-operation while PRESSED, partway through column 2.
        do_reset();
        run_scans(16'h0040, 4);
        mask = 16'h0040;
        repeat (25) @(posedge clk);
        #2;
        checking = 0;
        reset = 1'b1;
        #1;
        check("mid_rst_col", 32'(col), 32'hE);
        check("mid_rst_held", 32'(key_held), 0);
        check("mid_rst_code", 32'(key_code), 0);
        do_reset();
        run_scans(16'h0040, 4);
        check("rearm_pulse_cyc", 32'(first_pulse), 121);
        check("rearm_code", 32'(key_code), 6);

        // Hold key 15 for a long time.
        do_reset();
        run_scans(16'h8000, 20);
        run_scans(16'h0000, 1);
`ifdef KEYPAD_REPEAT_EN
        check("hold_pulses", 32'(pulse_cnt), 4);
`else
        check("hold_pulses", 32'(pulse_cnt), 1);
`endif
        check("hold_code", 32'(key_code), 15);

        // Randomized runs of empty, single, multi-key and repeated scans.
        do_reset();
        begin
            logic [15:0] m;
            m = '0;
            for (int s = 0; s < 60; s++) begin
                case ($urandom_range(0, 3))
                    0: m = '0;
                    1: m = 16'(1) << $urandom_range(0, 15);
                    2: m = (16'(1) << $urandom_range(0, 7)) | (16'(1) << $urandom_range(8, 15));
                    default: ;
                endcase
                run_scans(m, $urandom_range(1, 5));
            end
            run_scans(16'h0000, 4);
        end
        checking = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
